// File: rtl/axis_pkt_fifo_pkg.sv
// axis_pkt_fifo_pkg: shared types and helpers for the store-and-forward AXI4-Stream packet FIFO.
// Contents: wr_state_t write-side state enum, ptr_w() pointer width helper (index bits plus wrap bit).
// The beat struct depends on the top's width parameters, so it is declared in axis_pkt_fifo.
package axis_pkt_fifo_pkg;
   typedef enum logic {ACCEPT, DISCARD} wr_state_t;
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port RAM, one write port plus a registered read port.
// Ports: clk; we/waddr/wdata write port; re/raddr read request, rdata updates on the edge after re
// and holds its value while re is low.
module axis_fifo_ram #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: store-and-forward AXI4-Stream packet FIFO; only complete packets reach the master side.
// Ports: ACLK, ARESETn (async, active low); S_* slave stream in; M_* master stream out;
// PKT_COUNT = complete packets held (including one partly read); DROP = one-cycle pulse per discarded packet.
// Optional macro AXIS_PKT_FIFO_DROP_ON_USER_EN: a TLAST beat with S_TUSER[0]=1 discards its packet.
module axis_pkt_fifo import axis_pkt_fifo_pkg::*; #(
   parameter int N     = 1,
   parameter int I     = 1,
   parameter int D     = 1,
   parameter int U     = 1,
   parameter int DEPTH = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETn,
   input  logic                      S_TVALID,
   output logic                      S_TREADY,
   input  logic [8*N-1:0]            S_TDATA,
   input  logic [N-1:0]              S_TSTRB,
   input  logic [N-1:0]              S_TKEEP,
   input  logic [I-1:0]              S_TID,
   input  logic [D-1:0]              S_TDEST,
   input  logic [U-1:0]              S_TUSER,
   input  logic                      S_TLAST,
   output logic                      M_TVALID,
   input  logic                      M_TREADY,
   output logic [8*N-1:0]            M_TDATA,
   output logic [N-1:0]              M_TSTRB,
   output logic [N-1:0]              M_TKEEP,
   output logic [I-1:0]              M_TID,
   output logic [D-1:0]              M_TDEST,
   output logic [U-1:0]              M_TUSER,
   output logic                      M_TLAST,
   output logic [ptr_w(DEPTH)-1:0]   PKT_COUNT,
   output logic                      DROP
);
   localparam int PW = ptr_w(DEPTH);
   localparam int AW = PW - 1;
   localparam logic [PW-1:0] ONE = PW'(1);
   localparam logic [PW-1:0] DEP = PW'(DEPTH);

   typedef struct packed {
      logic [8*N-1:0] data;
      logic [N-1:0]   strb;
      logic [N-1:0]   keep;
      logic [I-1:0]   id;
      logic [D-1:0]   dest;
      logic [U-1:0]   user;
      logic           last;
   } beat_t;

   // rd_ptr advances only when a beat leaves on M, so beats sitting in the read
   // pipeline still occupy their RAM slot; fetch_ptr is the RAM read address.
   logic [PW-1:0] wr_ptr, commit_ptr, fetch_ptr, rd_ptr, wr_next;
   wr_state_t     state;
   logic          live, full, s_hs, m_hs, wr_en, oversize, user_drop, inc, dec;
   logic          fetch, a_v, load, m_v;
   beat_t         s_beat, a_beat, m_beat;

`ifdef AXIS_PKT_FIFO_DROP_ON_USER_EN
   assign user_drop = S_TUSER[0];
`else
   assign user_drop = 1'b0;
`endif

   assign s_beat   = {S_TDATA, S_TSTRB, S_TKEEP, S_TID, S_TDEST, S_TUSER, S_TLAST};
   assign wr_next  = wr_ptr + ONE;
   assign full     = (wr_ptr - rd_ptr) == DEP;
   // live holds S_TREADY low until the first clock after reset release
   assign S_TREADY = live && (state == DISCARD || !full);
   assign s_hs     = S_TVALID && S_TREADY;
   assign wr_en    = s_hs && state == ACCEPT;
   assign oversize = !S_TLAST && (wr_next - commit_ptr) == DEP;
   assign inc      = wr_en && S_TLAST && !user_drop;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         live       <= 1'b0;
         state      <= ACCEPT;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         DROP       <= 1'b0;
      end else begin
         live <= 1'b1;
         DROP <= 1'b0;
         if (wr_en) begin
            if (S_TLAST && !user_drop) begin
               wr_ptr     <= wr_next;
               commit_ptr <= wr_next;
            end else if (S_TLAST || oversize) begin
               // rewind over the partial packet; an oversize packet swallows its tail in DISCARD
               wr_ptr <= commit_ptr;
               DROP   <= 1'b1;
               state  <= S_TLAST ? ACCEPT : DISCARD;
            end else begin
               wr_ptr <= wr_next;
            end
         end else if (s_hs && S_TLAST) begin
            state <= ACCEPT;
         end
      end
   end

   axis_fifo_ram #(.W($bits(beat_t)), .AW(AW)) u_ram (
      .clk   (ACLK),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (s_beat),
      .re    (fetch),
      .raddr (fetch_ptr[AW-1:0]),
      .rdata (a_beat)
   );

   // Two-stage read: RAM read register (a_v) feeds the output register (m_v).
   // Both advance together whenever the output can accept, sustaining one beat per cycle.
   assign load  = a_v && (!m_v || M_TREADY);
   assign fetch = (!a_v || load) && fetch_ptr != commit_ptr && PKT_COUNT != '0;
   assign m_hs  = m_v && M_TREADY;
   assign dec   = m_hs && m_beat.last;

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         fetch_ptr <= '0;
         rd_ptr    <= '0;
         a_v       <= 1'b0;
         m_v       <= 1'b0;
         m_beat    <= '0;
         PKT_COUNT <= '0;
      end else begin
         if (fetch) fetch_ptr <= fetch_ptr + ONE;
         if (m_hs) rd_ptr <= rd_ptr + ONE;
         a_v <= fetch || (a_v && !load);
         m_v <= load || (m_v && !M_TREADY);
         if (load) m_beat <= a_beat;
         PKT_COUNT <= PKT_COUNT + PW'(inc) - PW'(dec);
      end
   end

   assign M_TVALID = m_v;
   assign M_TDATA  = m_beat.data;
   assign M_TSTRB  = m_beat.strb;
   assign M_TKEEP  = m_beat.keep;
   assign M_TID    = m_beat.id;
   assign M_TDEST  = m_beat.dest;
   assign M_TUSER  = m_beat.user;
   assign M_TLAST  = m_beat.last;
endmodule
